// File: rtl/tmds_pkg.sv
// Shared TMDS definitions: control tokens, link FSM states and token lookup.
// Used by the receive-side decoder and available to the encoder side.
package tmds_pkg;

    // Control tokens sent during blanking, bit 0 first on the wire.
    localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
    localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
    localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
    localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

    // Word-alignment state machine states.
    typedef enum logic [1:0] {
        SEARCH = 2'd0,
        SLIP   = 2'd1,
        LOCKED = 2'd2
    } tmds_state_e;

    // Token lookup: returns {is_token, ctrl[1:0]}; non-tokens give 3'b000.
    function automatic logic [2:0] token_to_ctrl(input logic [9:0] sym);
        logic [2:0] res;
        case (sym)
            TMDS_CTRL_00: res = 3'b100;
            TMDS_CTRL_01: res = 3'b101;
            TMDS_CTRL_10: res = 3'b110;
            TMDS_CTRL_11: res = 3'b111;
            default:      res = 3'b000;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/tmds_symbol_decode.sv
// Combinational decode of one 10-bit TMDS symbol into token flag,
// control bits and data byte. The data field is meaningful only for
// non-token symbols and the ctrl field only for tokens.
module tmds_symbol_decode
    import tmds_pkg::*;
(
    input  logic [9:0] sym_i,
    output logic       is_ctrl_o,
    output logic [1:0] ctrl_o,
    output logic [7:0] data_o
);

    logic [2:0] tok_s;
    logic [7:0] q_s;

    // Token lookup plus inversion / XOR-XNOR chain undo for data symbols.
    always_comb begin
        tok_s     = token_to_ctrl(sym_i);
        is_ctrl_o = tok_s[2];
        ctrl_o    = tok_s[1:0];
        q_s       = sym_i[9] ? ~sym_i[7:0] : sym_i[7:0];
        data_o    = 8'h00;
        data_o[0] = q_s[0];
        for (int i = 1; i < 8; i++) begin
            if (sym_i[8]) begin
                data_o[i] = q_s[i] ^ q_s[i-1];
            end else begin
                data_o[i] = ~(q_s[i] ^ q_s[i-1]);
            end
        end
    end

endmodule

// File: rtl/tmds_decoder.sv
// Per-channel TMDS receiver: word alignment via control-token runs with
// bitslip requests, then symbol decode into de/ctrl/data with 2-cycle
// latency. Optional lock-loss counter when TMDS_LOCK_STATS_EN is defined.
module tmds_decoder
    import tmds_pkg::*;
#(
    parameter int CTRL_RUN       = 64,
    parameter int SEARCH_TIMEOUT = 4096,
    parameter int SLIP_WAIT      = 8,
    parameter int CNTW           = 13
) (
    input  logic        clk_pix,
    input  logic        rst,
    input  logic [9:0]  sym_in,
    output logic        bitslip,
    output logic        locked,
    output logic        de,
    output logic [7:0]  data,
    output logic [1:0]  ctrl
`ifdef TMDS_LOCK_STATS_EN
    ,
    output logic [15:0] lock_losses
`endif
);

    localparam logic [CNTW-1:0] ZERO     = {CNTW{1'b0}};
    localparam logic [CNTW-1:0] ONE      = {{(CNTW-1){1'b0}}, 1'b1};
    localparam logic [CNTW-1:0] RUN_MAX  = CNTW'(CTRL_RUN);
    localparam logic [CNTW-1:0] TMO_MAX  = CNTW'(SEARCH_TIMEOUT);
    localparam logic [CNTW-1:0] WAIT_MAX = CNTW'(SLIP_WAIT);

    // Stage 1 registers
    logic [9:0]      sym_q;
    logic [9:0]      sym_prev_q;

    // Alignment state
    tmds_state_e     state_q;
    logic [CNTW-1:0] run_q;
    logic [CNTW-1:0] run_d;
    logic [CNTW-1:0] timeout_q;
    logic [CNTW-1:0] timeout_inc_s;
    logic [CNTW-1:0] slip_cnt_q;
    logic            bitslip_q;
    logic            locked_q;

    // Stage 2 output registers
    logic            de_q;
    logic [1:0]      ctrl_q;
    logic [7:0]      data_q;

    // Decode of the stage-1 symbol
    logic            dec_is_ctrl_s;
    logic [1:0]      dec_ctrl_s;
    logic [7:0]      dec_data_s;

    // Per-cycle events
    logic            run_hit_s;
    logic            tmo_hit_s;
    logic            lose_s;
    logic            lock_next_s;

    tmds_symbol_decode u_dec (
        .sym_i     (sym_q),
        .is_ctrl_o (dec_is_ctrl_s),
        .ctrl_o    (dec_ctrl_s),
        .data_o    (dec_data_s)
    );

    // Stage 1: capture the raw symbol and keep the previous one for run matching.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            sym_q      <= 10'h000;
            sym_prev_q <= 10'h000;
        end else begin
            sym_q      <= sym_in;
            sym_prev_q <= sym_q;
        end
    end

    // Next run length: held at zero while slipping, saturating at CTRL_RUN.
    always_comb begin
        run_d = ZERO;
        if (state_q == SLIP) begin
            run_d = ZERO;
        end else if (!dec_is_ctrl_s) begin
            run_d = ZERO;
        end else if (sym_q == sym_prev_q) begin
            if (run_q >= RUN_MAX) begin
                run_d = RUN_MAX;
            end else begin
                run_d = run_q + ONE;
            end
        end else begin
            run_d = ONE;
        end
    end

    // Event decode; a completed run takes priority over an expiring timeout.
    always_comb begin
        timeout_inc_s = timeout_q + ONE;
        run_hit_s     = (run_d == RUN_MAX);
        tmo_hit_s     = (timeout_inc_s == TMO_MAX);
        lose_s        = 1'b0;
        lock_next_s   = 1'b0;
        case (state_q)
            SEARCH: begin
                lock_next_s = run_hit_s;
            end
            LOCKED: begin
                lose_s      = tmo_hit_s && !run_hit_s;
                lock_next_s = !lose_s;
            end
            default: begin
                lock_next_s = 1'b0;
            end
        endcase
    end

    // Run counter register.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            run_q <= ZERO;
        end else begin
            run_q <= run_d;
        end
    end

    // Alignment FSM with registered bitslip and locked outputs.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            state_q    <= SEARCH;
            timeout_q  <= ZERO;
            slip_cnt_q <= ZERO;
            bitslip_q  <= 1'b0;
            locked_q   <= 1'b0;
        end else begin
            case (state_q)
                SEARCH: begin
                    bitslip_q <= 1'b0;
                    if (run_hit_s) begin
                        state_q   <= LOCKED;
                        locked_q  <= 1'b1;
                        timeout_q <= ZERO;
                    end else if (tmo_hit_s) begin
                        state_q    <= SLIP;
                        bitslip_q  <= 1'b1;
                        timeout_q  <= ZERO;
                        slip_cnt_q <= ZERO;
                    end else begin
                        timeout_q <= timeout_inc_s;
                    end
                end
                SLIP: begin
                    // One extra cycle past SLIP_WAIT guarantees pulse spacing
                    // of SEARCH_TIMEOUT + SLIP_WAIT + 1.
                    bitslip_q <= 1'b0;
                    if (slip_cnt_q == WAIT_MAX) begin
                        state_q    <= SEARCH;
                        timeout_q  <= ZERO;
                        slip_cnt_q <= ZERO;
                    end else begin
                        slip_cnt_q <= slip_cnt_q + ONE;
                    end
                end
                LOCKED: begin
                    bitslip_q <= 1'b0;
                    if (run_hit_s) begin
                        timeout_q <= ZERO;
                    end else if (tmo_hit_s) begin
                        state_q   <= SEARCH;
                        locked_q  <= 1'b0;
                        timeout_q <= ZERO;
                    end else begin
                        timeout_q <= timeout_inc_s;
                    end
                end
                default: begin
                    state_q    <= SEARCH;
                    timeout_q  <= ZERO;
                    slip_cnt_q <= ZERO;
                    bitslip_q  <= 1'b0;
                    locked_q   <= 1'b0;
                end
            endcase
        end
    end

    // Stage 2: decoded outputs, gated with the lock state they will appear alongside.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
            data_q <= 8'h00;
        end else if (!lock_next_s) begin
            de_q   <= 1'b0;
            ctrl_q <= 2'b00;
        end else if (dec_is_ctrl_s) begin
            de_q   <= 1'b0;
            ctrl_q <= dec_ctrl_s;
        end else begin
            de_q   <= 1'b1;
            data_q <= dec_data_s;
        end
    end

    assign bitslip = bitslip_q;
    assign locked  = locked_q;
    assign de      = de_q;
    assign ctrl    = ctrl_q;
    assign data    = data_q;

`ifdef TMDS_LOCK_STATS_EN
    logic [15:0] lock_losses_q;

    // Saturating count of LOCKED to SEARCH transitions.
    always_ff @(posedge clk_pix or posedge rst) begin
        if (rst) begin
            lock_losses_q <= 16'h0000;
        end else if (lose_s && (lock_losses_q != 16'hFFFF)) begin
            lock_losses_q <= lock_losses_q + 16'h0001;
        end else begin
            lock_losses_q <= lock_losses_q;
        end
    end

    assign lock_losses = lock_losses_q;
`endif

endmodule

// File: tb/tb_tmds_decoder.sv
// Self-checking bench for tmds_decoder: directed vectors with hand-computed
// expectations, an independent TMDS encoder model and a rotating-deserialiser
// model for the alignment search.
module tb_tmds_decoder;

    localparam logic [9:0] TOK00 = 10'b1101010100;
    localparam logic [9:0] TOK01 = 10'b0010101011;
    localparam logic [9:0] TOK10 = 10'b0101010100;
    localparam logic [9:0] TOK11 = 10'b1010101011;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [9:0]  sym_in = 10'h000;
    logic        bitslip;
    logic        locked;
    logic        de;
    logic [7:0]  data;
    logic [1:0]  ctrl;
`ifdef TMDS_LOCK_STATS_EN
    logic [15:0] lock_losses;
`endif

    int n_cmp = 0;
    int n_bad = 0;
    int enc_cnt = 0;

    tmds_decoder dut (
        .clk_pix (clk),
        .rst     (rst),
        .sym_in  (sym_in),
        .bitslip (bitslip),
        .locked  (locked),
        .de      (de),
        .data    (data),
        .ctrl    (ctrl)
`ifdef TMDS_LOCK_STATS_EN
        ,
        .lock_losses (lock_losses)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] sym;
        logic       exp_de;
        logic [1:0] exp_ctrl;
        logic [7:0] exp_data;
    } vec_t;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        sym_in = 10'h000;
        step();
        step();
        rst = 1'b0;
    endtask

    // Reference DVI TMDS encoder with running disparity in enc_cnt.
    task automatic encode(input logic [7:0] d, output logic [9:0] s);
        int n1, n1q, n0q;
        logic [8:0] qm;
        n1 = $countones(d);
        qm = 9'h000;
        qm[0] = d[0];
        if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
            for (int i = 1; i < 8; i++) qm[i] = ~(qm[i-1] ^ d[i]);
            qm[8] = 1'b0;
        end else begin
            for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
            qm[8] = 1'b1;
        end
        n1q = $countones(qm[7:0]);
        n0q = 8 - n1q;
        if (enc_cnt == 0 || n1q == n0q) begin
            s = {~qm[8], qm[8], (qm[8] ? qm[7:0] : ~qm[7:0])};
            if (qm[8]) enc_cnt = enc_cnt + n1q - n0q;
            else       enc_cnt = enc_cnt + n0q - n1q;
        end else if ((enc_cnt > 0 && n1q > n0q) || (enc_cnt < 0 && n0q > n1q)) begin
            s = {1'b1, qm[8], ~qm[7:0]};
            enc_cnt = enc_cnt + (qm[8] ? 2 : 0) + n0q - n1q;
        end else begin
            s = {1'b0, qm[8], qm[7:0]};
            enc_cnt = enc_cnt - (qm[8] ? 0 : 2) + n1q - n0q;
        end
    endtask

    // Aligned wire stream: 280 blanking tokens per 2200-symbol line.
    function automatic logic [9:0] sym_at(input int n);
        int p;
        logic [9:0] s;
        p = n % 2200;
        if (p < 280) begin
            s = TOK00;
        end else begin
            s = {2'b01, 8'(p)};
            if (s == TOK10) s = 10'h155;
        end
        return s;
    endfunction

    vec_t tbl[11];

    initial begin
        logic [9:0]  s;
        logic [19:0] w20;
        int rot, pulses, last_edge, cnt;
        logic prev_bs, slip_seen;

        tbl[0]  = '{10'h1F0, 1'b1, 2'b00, 8'h10};
        tbl[1]  = '{TOK01,   1'b0, 2'b01, 8'h10};
        tbl[2]  = '{TOK10,   1'b0, 2'b10, 8'h10};
        tbl[3]  = '{TOK11,   1'b0, 2'b11, 8'h10};
        tbl[4]  = '{TOK00,   1'b0, 2'b00, 8'h10};
        tbl[5]  = '{10'h100, 1'b1, 2'b00, 8'h00};
        tbl[6]  = '{10'h2FF, 1'b1, 2'b00, 8'hFE};
        tbl[7]  = '{TOK11,   1'b0, 2'b11, 8'hFE};
        tbl[8]  = '{10'h055, 1'b1, 2'b11, 8'h01};
        tbl[9]  = '{10'h1AA, 1'b1, 2'b11, 8'hFE};
        tbl[10] = '{10'h3C3, 1'b1, 2'b11, 8'h44};

        // Reset state
        do_reset();
        chk("rst_bitslip", int'(bitslip), 0);
        chk("rst_locked", int'(locked), 0);
        chk("rst_de", int'(de), 0);
        chk("rst_data", int'(data), 0);
        chk("rst_ctrl", int'(ctrl), 0);

        // 100 blanking tokens: lock two cycles after the 64th
        for (int n = 1; n <= 100; n++) begin
            sym_in = TOK00;
            step();
            if (n == 64) chk("lock_early", int'(locked), 0);
            if (n == 65) chk("lock_rise", int'(locked), 1);
        end
        chk("tok_de", int'(de), 0);
        chk("tok_ctrl", int'(ctrl), 0);

        // Table: data and all four tokens, 2-cycle latency
        for (int i = 0; i <= 11; i++) begin
            if (i < 11) sym_in = tbl[i].sym;
            step();
            if (i > 0) begin
                chk("vec_de", int'(de), int'(tbl[i-1].exp_de));
                chk("vec_ctrl", int'(ctrl), int'(tbl[i-1].exp_ctrl));
                chk("vec_data", int'(data), int'(tbl[i-1].exp_data));
            end
        end

        // All 256 encoded bytes, then data-only until lock is lost
        do_reset();
        for (int n = 0; n < 70; n++) begin
            sym_in = TOK00;
            step();
        end
        chk("relock", int'(locked), 1);
        enc_cnt = 0;
        slip_seen = 1'b0;
        for (int n = 1; n <= 5000; n++) begin
            encode(8'((n - 1) & 255), s);
            sym_in = s;
            step();
            slip_seen = slip_seen | bitslip;
            if (n >= 2 && n <= 257) begin
                chk("byte_data", int'(data), (n - 2) & 255);
                chk("byte_de", int'(de), 1);
            end
            if (n == 4096) chk("hold_lock", int'(locked), 1);
            if (n == 4097) begin
                chk("lose_lock", int'(locked), 0);
                chk("lose_de", int'(de), 0);
            end
        end
        chk("loss_no_slip", int'(slip_seen), 0);
        chk("loss_de", int'(de), 0);

        // Stream rotated by 3 bits: three slips then lock
        do_reset();
        rot = 3;
        pulses = 0;
        last_edge = -1;
        prev_bs = 1'b0;
        for (int n = 0; n < 30000 && !locked; n++) begin
            w20 = {sym_at(n + 1), sym_at(n)};
            w20 = w20 >> rot;
            sym_in = w20[9:0];
            step();
            if (bitslip) begin
                pulses++;
                chk("slip_width", int'(prev_bs), 0);
                if (last_edge >= 0) chk("slip_spacing", n - last_edge, 4105);
                last_edge = n;
                if (rot > 0) rot--;
            end
            prev_bs = bitslip;
        end
        chk("slip_count", pulses, 3);
        chk("rot_locked", int'(locked), 1);

        // Reset asserted while bitslip is high
        do_reset();
        sym_in = 10'h100;
        cnt = 0;
        while (!bitslip && cnt < 5000) begin
            step();
            cnt++;
        end
        chk("slip_at", cnt, 4096);
        #2;
        rst = 1'b1;
        #1;
        chk("async_bitslip", int'(bitslip), 0);
        chk("async_locked", int'(locked), 0);
        step();
        rst = 1'b0;

`ifdef TMDS_LOCK_STATS_EN
        // Two forced lock losses
        do_reset();
        chk("stats_rst", int'(lock_losses), 0);
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 70; n++) begin
                sym_in = TOK00;
                step();
            end
            sym_in = 10'h100;
            for (int n = 0; n < 4200; n++) step();
        end
        chk("stats_unlocked", int'(locked), 0);
        chk("stats_losses", int'(lock_losses), 2);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
